// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_seq_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_seq_adder_slice.sv
// Purely combinational 4-bit carry-lookahead slice; c3 is the carry into the top bit.
module cla4_slice
    import cla_seq_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry expanded directly from g/p and cin, so no carry waits on its neighbour.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];
    assign c3   = c[SLICE_W-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential add/subtract: one 4-bit CLA slice per cycle, LSB slice first.
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W  = SLICE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     result;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_sum;
    logic               sl_cout;
    logic               sl_c3;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                sl_a = a_q[i*SLICE_W +: SLICE_W];
                sl_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cla4_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout),
        .c3   (sl_c3)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)      state_nx = RUN;
            RUN:     if (idx == LAST)   state_nx = DONE;
            DONE:    if (out_ready)     state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Subtraction is A + ~B + 1: B is inverted on capture and the +1 enters as carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {W{sub}};
            carry <= sub;
            idx   <= '0;
        end else if (state == RUN) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (idx == IW'(i)) result[i*SLICE_W +: SLICE_W] <= sl_sum;
            end
            carry <= sl_cout;
            idx   <= idx + IW'(1);
            if (idx == LAST) begin
                cout_q <= sl_cout;
                ovf_q  <= sl_c3 ^ sl_cout;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = result;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder at NIBBLES=4 and NIBBLES=2 with a result scoreboard.
module tb_cla_seq_adder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        sel   = 1'b0;
    logic        iv    = 1'b0;
    logic        orr   = 1'b0;
    logic        ts    = 1'b0;
    logic [15:0] ta    = '0;
    logic [15:0] tb    = '0;

    always #5 clk = ~clk;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, cout4, ovf4;
    logic [15:0] sum4;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, cout2, ovf2;
    logic [7:0]  sum2;

    assign in_valid4  = iv & ~sel;
    assign out_ready4 = orr & ~sel;
    assign in_valid2  = iv & sel;
    assign out_ready2 = orr & sel;

    cla_seq_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(ta), .b(tb), .sub(ts), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    cla_seq_adder #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(ta[7:0]), .b(tb[7:0]), .sub(ts), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    // Views of whichever instance is selected.
    logic        rdy, ov, co, of;
    logic [15:0] so;
    assign rdy = sel ? in_ready2  : in_ready4;
    assign ov  = sel ? out_valid2 : out_valid4;
    assign co  = sel ? cout2      : cout4;
    assign of  = sel ? ovf2       : ovf4;
    assign so  = sel ? {8'h00, sum2} : sum4;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] sbq[$];

    // Reference: {ovf, cout, sum} of x +/- y at width w.
    function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
        logic [16:0] full;
        logic [15:0] mask, xx, yy, r;
        logic        c, v;
        mask = 16'((17'd1 << w) - 17'd1);
        xx   = x & mask;
        yy   = (s ? ~y : y) & mask;
        full = {1'b0, xx} + {1'b0, yy} + 17'(s);
        r    = full[15:0] & mask;
        c    = full[w];
        v    = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
        return {v, c, r};
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input int gin, input int gout, input bit hold);
        logic [17:0] exp;
        int          lat;
        sbq.push_back(model(sel ? 8 : 16, x, y, s));
        repeat (gin) begin @(posedge clk); #1; end
        ta = x; tb = y; ts = s; iv = 1'b1;
        lat = 0;
        while (!rdy && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("accept_ready", 18'(rdy), 18'd1);
        @(posedge clk); #1;
        // Junk operands while busy must not disturb the latched ones.
        iv = hold; ta = 16'($urandom); tb = 16'($urandom); ts = 1'($urandom_range(0, 1));
        lat = 1;
        while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("latency", 18'(lat), sel ? 18'd3 : 18'd5);
        exp = sbq.pop_front();
        for (int k = 0; k < gout; k++) begin
            if (hold) begin
                chk("hold_valid", 18'(ov), 18'd1);
                chk("hold_result", {of, co, so}, exp);
                chk("hold_in_ready", 18'(rdy), 18'd0);
            end
            @(posedge clk); #1;
        end
        chk("out_valid", 18'(ov), 18'd1);
        chk("result", {of, co, so}, exp);
        iv = 1'b0; orr = 1'b1;
        @(posedge clk); #1;
        orr = 1'b0;
        chk("release_valid", 18'(ov), 18'd0);
        chk("release_ready", 18'(rdy), 18'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid4", 18'(out_valid4), 18'd0);
        chk("rst_out4", {ovf4, cout4, sum4}, 18'd0);
        chk("rst_in_ready4", 18'(in_ready4), 18'd1);
        chk("rst_out_valid2", 18'(out_valid2), 18'd0);
        chk("rst_out2", {ovf2, cout2, 8'h00, sum2}, 18'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 18'(in_ready4), 18'd1);

        sel = 1'b0;
        do_op(16'h1234, 16'h4321, 1'b0, 0, 0, 1'b0);
        chk("dir_1234_4321", {of, co, so}, {1'b0, 1'b0, 16'h5555});
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1, 1'b0);
        chk("dir_ffff_0001", {of, co, so}, {1'b0, 1'b1, 16'h0000});
        do_op(16'h7FFF, 16'h0001, 1'b0, 1, 0, 1'b0);
        chk("dir_7fff_0001", {of, co, so}, {1'b1, 1'b0, 16'h8000});
        do_op(16'h0003, 16'h0005, 1'b1, 0, 2, 1'b0);
        chk("dir_3_minus_5", {of, co, so}, {1'b0, 1'b0, 16'hFFFE});
        do_op(16'h8000, 16'h8001, 1'b0, 0, 10, 1'b1);

        // Abort mid-operation with an asynchronous reset.
        ta = 16'h1111; tb = 16'h1111; ts = 1'b0; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 18'(ov), 18'd0);
        chk("abort_outputs", {of, co, so}, 18'd0);
        chk("abort_in_ready", 18'(rdy), 18'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 18'(ov), 18'd0);
        end
        do_op(16'h1234, 16'h4321, 1'b0, 0, 0, 1'b0);
        chk("after_abort", {of, co, so}, {1'b0, 1'b0, 16'h5555});

        for (int i = 0; i < 500; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

        sel = 1'b1;
        #1;
        do_op(16'h00FF, 16'h0001, 1'b0, 0, 0, 1'b0);
        chk("n2_ff_01", {of, co, so}, {1'b0, 1'b1, 16'h0000});
        do_op(16'h007F, 16'h0001, 1'b0, 0, 0, 1'b0);
        chk("n2_7f_01", {of, co, so}, {1'b1, 1'b0, 16'h0080});
        for (int i = 0; i < 500; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
